// File: rtl/vdp_pkg.sv
// Shared definitions for the vdp register loader: register names, the boot table,
// loader state encoding and table lookup helpers.
package vdp_pkg;

    localparam logic [7:0] VDP_R02 = 8'h02;
    localparam logic [7:0] VDP_R03 = 8'h03;
    localparam logic [7:0] VDP_R04 = 8'h04;
    localparam logic [7:0] VDP_R05 = 8'h05;
    localparam logic [7:0] VDP_R06 = 8'h06;
    localparam logic [7:0] VDP_R07 = 8'h07;
    localparam logic [7:0] VDP_R08 = 8'h08;
    localparam logic [7:0] VDP_R09 = 8'h09;
    localparam logic [7:0] VDP_R0A = 8'h0A;
    localparam logic [7:0] VDP_R0B = 8'h0B;
    localparam logic [7:0] VDP_R0C = 8'h0C;

    typedef struct packed {
        logic [7:0] index;
        logic [7:0] value;
    } vdp_init_entry_t;

    localparam int VDP_INIT_LEN  = 11;
    localparam int VDP_TBL_IDX_W = 5;

    localparam vdp_init_entry_t [0:VDP_INIT_LEN-1] VDP_INIT_TABLE = '{
        '{VDP_R04, 8'h4F}, '{VDP_R05, 8'h15}, '{VDP_R06, 8'h01}, '{VDP_R07, 8'h3B},
        '{VDP_R08, 8'h27}, '{VDP_R09, 8'h00}, '{VDP_R0A, 8'h35}, '{VDP_R0B, 8'h00},
        '{VDP_R0C, 8'h20}, '{VDP_R02, 8'h00}, '{VDP_R03, 8'h20}
    };

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_IDX        = 3'd1;
    localparam logic [2:0] ST_IDX_GAP    = 3'd2;
    localparam logic [2:0] ST_VAL        = 3'd3;
    localparam logic [2:0] ST_VAL_GAP    = 3'd4;
    localparam logic [2:0] ST_REPLAY     = 3'd5;
    localparam logic [2:0] ST_REPLAY_GAP = 3'd6;

    // Entries past the end of the boot table read as zero.
    function automatic vdp_init_entry_t vdp_table_entry(input logic [VDP_TBL_IDX_W-1:0] i);
        vdp_init_entry_t e;
        e = '0;
        for (int k = 0; k < VDP_INIT_LEN; k++) begin
            if (i == VDP_TBL_IDX_W'(k)) e = VDP_INIT_TABLE[k];
        end
        return e;
    endfunction

    function automatic logic [7:0] vdp_table_index(input logic [VDP_TBL_IDX_W-1:0] i);
        vdp_init_entry_t e;
        e = vdp_table_entry(i);
        return e.index;
    endfunction

    function automatic logic [7:0] vdp_table_value(input logic [VDP_TBL_IDX_W-1:0] i);
        vdp_init_entry_t e;
        e = vdp_table_entry(i);
        return e.value;
    endfunction

endpackage

// File: rtl/vdp_strobe_timer.sv
// Loadable down-counter; expired is high on the last cycle of a strobe or gap phase.
module vdp_strobe_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/vdp_reg_loader.sv
// Boot/reconfigure sequencer owning the vdp register port: walks the init table with
// stretched index/value strobes, passes CPU traffic through when idle.
module vdp_reg_loader
    import vdp_pkg::*;
#(
    parameter int NUM_ENTRIES = 11,
    parameter int STROBE_LEN  = 4,
    parameter int GAP_LEN     = 4,
    parameter bit AUTO_START  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    input  logic [1:0] cpu_mode,
    input  logic       cpu_read,
    input  logic       cpu_write,
    input  logic [7:0] cpu_data_in,
    output logic       cpu_wait,
    output logic [1:0] vdp_mode,
    output logic       vdp_read,
    output logic       vdp_write,
    output logic [7:0] vdp_data_in
);

    localparam int PTR_W     = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int PHASE_MAX = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
    localparam int CNT_W     = $clog2(PHASE_MAX) + 1;

    localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(NUM_ENTRIES - 1);
    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_LEN - 1);

    logic [2:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nx;
    logic             pend_valid;
    logic [1:0]       pend_mode;
    logic [7:0]       pend_data;
    logic             auto_pend;
    logic             go;
    logic             own;
    logic             expired;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic [7:0]       first_index;
    logic [7:0]       cur_value;
    logic [7:0]       nxt_index;

    // Handshake: the CPU may issue a read/write only while cpu_wait is low; an access
    // made with cpu_wait high is either captured into the one-deep buffer or dropped
    // with overflow set, never forwarded to the vdp directly.
    assign cpu_wait = busy | pend_valid;

    always_comb begin
        go          = (state == ST_IDLE) && (start || auto_pend);
        own         = (state != ST_IDLE) || go || pend_valid;
        ptr_nx      = ptr + 1'b1;
        first_index = vdp_table_index('0);
        cur_value   = vdp_table_value(VDP_TBL_IDX_W'(ptr));
        nxt_index   = vdp_table_index(VDP_TBL_IDX_W'(ptr_nx));
        timer_val   = ((state == ST_IDX) || (state == ST_VAL) || (state == ST_REPLAY))
                      ? GAP_LOAD : STROBE_LOAD;
        timer_load  = (state == ST_IDLE) ? (go || pend_valid) : expired;
    end

    vdp_strobe_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            pend_valid  <= 1'b0;
            pend_mode   <= '0;
            pend_data   <= '0;
            auto_pend   <= AUTO_START;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            vdp_mode    <= '0;
            vdp_read    <= 1'b0;
            vdp_write   <= 1'b0;
            vdp_data_in <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state       <= ST_IDX;
                        ptr         <= '0;
                        auto_pend   <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        overflow    <= 1'b0;
                        vdp_mode    <= 2'd0;
                        vdp_data_in <= first_index;
                        vdp_read    <= 1'b0;
                        vdp_write   <= 1'b1;
                    end else if (pend_valid) begin
                        state       <= ST_REPLAY;
                        vdp_mode    <= pend_mode;
                        vdp_data_in <= pend_data;
                        vdp_read    <= 1'b0;
                        vdp_write   <= 1'b1;
                    end else begin
                        vdp_mode    <= cpu_mode;
                        vdp_data_in <= cpu_data_in;
                        vdp_read    <= cpu_read;
                        vdp_write   <= cpu_write;
                    end
                end
                ST_IDX: begin
                    if (expired) begin
                        state     <= ST_IDX_GAP;
                        vdp_write <= 1'b0;
                    end
                end
                ST_IDX_GAP: begin
                    if (expired) begin
                        state       <= ST_VAL;
                        vdp_mode    <= 2'd1;
                        vdp_data_in <= cur_value;
                        vdp_write   <= 1'b1;
                    end
                end
                ST_VAL: begin
                    if (expired) begin
                        state     <= ST_VAL_GAP;
                        vdp_write <= 1'b0;
                    end
                end
                ST_VAL_GAP: begin
                    if (expired) begin
                        if (ptr != LAST_PTR) begin
                            ptr         <= ptr_nx;
                            state       <= ST_IDX;
                            vdp_mode    <= 2'd0;
                            vdp_data_in <= nxt_index;
                            vdp_write   <= 1'b1;
                        end else begin
                            done <= 1'b1;
                            busy <= 1'b0;
                            if (pend_valid) begin
                                state       <= ST_REPLAY;
                                vdp_mode    <= pend_mode;
                                vdp_data_in <= pend_data;
                                vdp_write   <= 1'b1;
                            end else begin
                                state     <= ST_IDLE;
                                vdp_write <= 1'b0;
                            end
                        end
                    end
                end
                ST_REPLAY: begin
                    if (expired) begin
                        state     <= ST_REPLAY_GAP;
                        vdp_write <= 1'b0;
                    end
                end
                ST_REPLAY_GAP: begin
                    if (expired) begin
                        state      <= ST_IDLE;
                        pend_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Placed after the FSM so an access in a start cycle still sets overflow.
            if (own) begin
                if (cpu_write) begin
                    if (!pend_valid) begin
                        pend_valid <= 1'b1;
                        pend_mode  <= cpu_mode;
                        pend_data  <= cpu_data_in;
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                if (cpu_read) overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vdp_reg_loader.sv
// Self-checking bench for vdp_reg_loader: directed boot/replay/reset sequences, a
// pass-through vector table and randomized CPU traffic against a pulse-level model.
module tb_vdp_reg_loader;

    typedef logic [17:0] pulse_t;   // {mode, data, length in clk}

    typedef struct {
        logic [1:0] mode;
        logic       rd;
        logic       wr;
        logic [7:0] data;
        logic [1:0] e_mode;
        logic       e_rd;
        logic       e_wr;
        logic [7:0] e_data;
    } vec_t;

    localparam int N_ENT = 11;
    localparam int LOAD_CYC = 176;

    logic [7:0] ref_idx [N_ENT] = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                                    8'h0A, 8'h0B, 8'h0C, 8'h02, 8'h03};
    logic [7:0] ref_val [N_ENT] = '{8'h4F, 8'h15, 8'h01, 8'h3B, 8'h27, 8'h00,
                                    8'h35, 8'h00, 8'h20, 8'h00, 8'h20};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] cpu_mode = '0;
    logic       cpu_read = 1'b0;
    logic       cpu_write = 1'b0;
    logic [7:0] cpu_data_in = '0;
    logic       busy, done, overflow, cpu_wait;
    logic [1:0] vdp_mode;
    logic       vdp_read, vdp_write;
    logic [7:0] vdp_data_in;

    int checks = 0;
    int passes = 0;
    pulse_t exp_q[$];
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    vdp_reg_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .cpu_mode    (cpu_mode),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_data_in (cpu_data_in),
        .cpu_wait    (cpu_wait),
        .vdp_mode    (vdp_mode),
        .vdp_read    (vdp_read),
        .vdp_write   (vdp_write),
        .vdp_data_in (vdp_data_in)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic pulse_t mk(input logic [1:0] m, input logic [7:0] d, input int len);
        return {m, d, 8'(len)};
    endfunction

    task automatic push_load();
        for (int i = 0; i < N_ENT; i++) begin
            exp_q.push_back(mk(2'd0, ref_idx[i], 4));
            exp_q.push_back(mk(2'd1, ref_val[i], 4));
        end
    endtask

    // Scoreboard: every completed vdp_write pulse is compared with the queue head.
    int run = 0;
    logic [1:0] run_mode;
    logic [7:0] run_data;
    always @(negedge clk) begin
        if (!mon_en) begin
            run = 0;
        end else if (vdp_write) begin
            if (run == 0) begin
                run_mode = vdp_mode;
                run_data = vdp_data_in;
            end
            run++;
        end else if (run != 0) begin
            if (exp_q.size() == 0) check("unexpected_pulse", 32'(mk(run_mode, run_data, run)), 32'h0);
            else check("vdp_pulse", 32'(mk(run_mode, run_data, run)), 32'(exp_q.pop_front()));
            run = 0;
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic cpu_wr(input logic [1:0] m, input logic [7:0] d);
        cpu_mode = m;
        cpu_data_in = d;
        cpu_write = 1'b1;
        @(negedge clk);
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd();
        cpu_read = 1'b1;
        @(negedge clk);
        cpu_read = 1'b0;
    endtask

    task automatic wait_done(input int c_in, output int c_out);
        int c;
        c = c_in;
        while (!done && c < 400) begin
            @(negedge clk);
            c++;
        end
        c_out = c;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cpu_wait && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 32'(n < 100), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int c, t, k, nw;
        logic rd, rd_done, exp_ovf;
        logic [1:0] m;
        logic [7:0] d;
        logic [9:0] wq[$];

        vecs[0] = '{2'd0, 1'b0, 1'b1, 8'h07, 2'd0, 1'b0, 1'b1, 8'h07};
        vecs[1] = '{2'd1, 1'b0, 1'b1, 8'h80, 2'd1, 1'b0, 1'b1, 8'h80};
        vecs[2] = '{2'd2, 1'b1, 1'b0, 8'h3C, 2'd2, 1'b1, 1'b0, 8'h3C};
        vecs[3] = '{2'd3, 1'b0, 1'b0, 8'hFF, 2'd3, 1'b0, 1'b0, 8'hFF};
        vecs[4] = '{2'd0, 1'b1, 1'b1, 8'h00, 2'd0, 1'b1, 1'b1, 8'h00};
        vecs[5] = '{2'd1, 1'b0, 1'b0, 8'h55, 2'd1, 1'b0, 1'b0, 8'h55};

        // Reset state, then the automatic boot load.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        check("rst_vdp", 32'({vdp_mode, vdp_read, vdp_write, vdp_data_in}), 32'd0);
        push_load();
        mon_en = 1'b1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("boot_write", 32'(vdp_write), 32'((i < 4) || (i >= 8 && i < 12)));
            check("boot_mode", 32'(vdp_mode), (i >= 8) ? 32'd1 : 32'd0);
            check("boot_data", 32'(vdp_data_in), (i >= 8) ? 32'h4F : 32'h04);
            if (i == 0) check("boot_busy", 32'(busy), 32'd1);
        end
        wait_done(15, c);
        check("boot_done_latency", 32'(c), 32'(LOAD_CYC));
        check("boot_busy_end", 32'(busy), 32'd0);
        check("boot_pulses_left", 32'(exp_q.size()), 32'd0);

        // One buffered write during a load is replayed after done.
        push_load();
        exp_q.push_back(mk(2'd1, 8'hAA, 4));
        do_start();
        repeat (50) @(negedge clk);
        cpu_wr(2'd1, 8'hAA);
        check("buf_cpu_wait", 32'(cpu_wait), 32'd1);
        wait_done(51, c);
        check("buf_done_latency", 32'(c), 32'(LOAD_CYC));
        wait_idle();
        check("buf_overflow", 32'(overflow), 32'd0);
        check("buf_pulses_left", 32'(exp_q.size()), 32'd0);

        // Two writes: first replayed, second dropped; start while busy is ignored.
        push_load();
        exp_q.push_back(mk(2'd2, 8'h11, 4));
        do_start();
        repeat (20) @(negedge clk);
        cpu_wr(2'd2, 8'h11);
        repeat (10) @(negedge clk);
        cpu_wr(2'd3, 8'h22);
        repeat (10) @(negedge clk);
        check("ovf_set", 32'(overflow), 32'd1);
        do_start();
        check("busy_start_ovf_kept", 32'(overflow), 32'd1);
        check("busy_start_busy", 32'(busy), 32'd1);
        wait_done(43, c);
        check("ovf_done_latency", 32'(c), 32'(LOAD_CYC));
        wait_idle();
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_pulses_left", 32'(exp_q.size()), 32'd0);

        // New start clears flags; reset during entry 5 aborts and the boot restarts.
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(mk(2'd0, ref_idx[i], 4));
            exp_q.push_back(mk(2'd1, ref_val[i], 4));
        end
        exp_q.push_back(mk(2'd0, ref_idx[5], 4));
        do_start();
        check("restart_ovf_clr", 32'(overflow), 32'd0);
        check("restart_done_clr", 32'(done), 32'd0);
        repeat (89) @(negedge clk);
        check("e5_val_strobe", 32'({vdp_write, vdp_mode, vdp_data_in}), 32'({1'b1, 2'd1, ref_val[5]}));
        check("e5_pulses_left", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("abort_write", 32'(vdp_write), 32'd0);
        check("abort_busy_done", 32'({busy, done}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        push_load();
        mon_en = 1'b1;
        reset = 1'b0;
        @(negedge clk);
        check("reboot_first", 32'({vdp_write, vdp_mode, vdp_data_in}), 32'({1'b1, 2'd0, 8'h04}));
        repeat (100) @(negedge clk);
        check("reboot_done_low", 32'(done), 32'd0);
        wait_done(100, c);
        check("reboot_done_latency", 32'(c), 32'(LOAD_CYC));
        check("reboot_pulses_left", 32'(exp_q.size()), 32'd0);

        // Idle pass-through vector table.
        mon_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cpu_mode = vecs[i].mode;
            cpu_read = vecs[i].rd;
            cpu_write = vecs[i].wr;
            cpu_data_in = vecs[i].data;
            @(negedge clk);
            check($sformatf("pass_vec%0d", i), 32'({vdp_mode, vdp_read, vdp_write, vdp_data_in}),
                  32'({vecs[i].e_mode, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_data}));
        end
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Single-cycle write in idle: one-clk pulse, one clk of latency.
        exp_q.push_back(mk(2'd0, 8'h07, 1));
        cpu_wr(2'd0, 8'h07);
        check("pass_single", 32'({vdp_write, vdp_mode, vdp_data_in}), 32'({1'b1, 2'd0, 8'h07}));
        @(negedge clk);
        check("pass_single_end", 32'(vdp_write), 32'd0);

        // Randomized idle traffic and CPU activity during loads.
        for (int it = 0; it < 8; it++) begin
            nw = $urandom_range(0, 3);
            for (int j = 0; j < nw; j++) begin
                m = 2'($urandom_range(0, 3));
                d = 8'($urandom_range(0, 255));
                exp_q.push_back(mk(m, d, 1));
                cpu_wr(m, d);
                @(negedge clk);
            end
            k = $urandom_range(0, 3);
            rd = ($urandom_range(0, 3) == 0);
            rd_done = 1'b0;
            wq.delete();
            push_load();
            do_start();
            c = 0;
            t = 0;
            for (int e = 0; e < k + 1; e++) begin
                t += int'($urandom_range(2, 35));
                if (t > 165) break;
                while (c < t) begin
                    @(negedge clk);
                    c++;
                end
                if (e < k) begin
                    m = 2'($urandom_range(0, 3));
                    d = 8'($urandom_range(0, 255));
                    wq.push_back({m, d});
                    cpu_wr(m, d);
                    c++;
                end else if (rd) begin
                    cpu_rd();
                    c++;
                    rd_done = 1'b1;
                end
            end
            if (wq.size() > 0) exp_q.push_back(mk(wq[0][9:8], wq[0][7:0], 4));
            exp_ovf = (wq.size() > 1) || rd_done;
            wait_done(c, c);
            check("rnd_done_latency", 32'(c), 32'(LOAD_CYC));
            wait_idle();
            check("rnd_overflow", 32'(overflow), 32'(exp_ovf));
            check("rnd_done", 32'(done), 32'd1);
            check("rnd_pulses_left", 32'(exp_q.size()), 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
